reorder_buffer: RTL and testbench

- Circular reorder buffer behind the issue stage of the Tomasulo RV32I core.
- Accepts one decoded instruction per cycle from issue and returns the allocated entry name (tag).
- Captures results from the common data bus (CDB) and commits in program order, one per cycle, to the register file or the load/store buffer.
- Detects branch and JALR redirects at commit and raises a pipeline clear.

---
 rtl/reorder_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer behind issue: allocates tags, captures CDB results,
// retires in program order and raises a pipeline clear on branch/JALR redirects.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ID_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            issue_sgn,
  input  logic [5:0]      issue_opcode,
  input  logic            issue_ready,
  input  logic [31:0]     issue_value,
  input  logic [4:0]      issue_dest,
  input  logic            issue_jumped,
  input  logic [31:0]     issue_jumpto,
  output logic [ID_W-1:0] rob_name,
  output logic            rob_full,
  input  logic            cdb_sgn,
  input  logic [ID_W-1:0] cdb_name,
  input  logic [31:0]     cdb_value,
  input  logic            cdb_taken,
  input  logic [31:0]     cdb_target,
  output logic            commit_reg_sgn,
  output logic [4:0]      commit_rd,
  output logic [31:0]     commit_value,
  output logic [ID_W-1:0] commit_name,
  output logic            commit_store_sgn,
  output logic [ID_W-1:0] commit_lsb_name,
  output logic            clear_sgn,
  output logic [31:0]     clear_pc
);
  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BTYPE = 6'd5;
  localparam logic [5:0] OP_LTYPE = 6'd6;
  localparam logic [5:0] OP_STYPE = 6'd7;
  localparam logic [5:0] OP_ITYPE = 6'd8;
  localparam logic [5:0] OP_RTYPE = 6'd9;

  localparam logic [ID_W:0]   C_CAP  = (ID_W+1)'(ROB_SIZE);
  localparam logic [ID_W:0]   C_ONE  = (ID_W+1)'(1);
  localparam logic [ID_W-1:0] C_STEP = ID_W'(1);

  function automatic logic f_writes_rd(input logic [5:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LTYPE, OP_ITYPE, OP_RTYPE: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_tgt_rdy;
  logic [ROB_SIZE-1:0] r_taken;
  logic [ROB_SIZE-1:0] r_jumped;
  logic [5:0]          r_opcode [ROB_SIZE];
  logic [31:0]         r_value  [ROB_SIZE];
  logic [4:0]          r_dest   [ROB_SIZE];
  logic [31:0]         r_jumpto [ROB_SIZE];

  logic [ID_W-1:0] r_head;
  logic [ID_W-1:0] r_tail;
  logic [ID_W:0]   r_count;

  logic [5:0] w_head_op;
  logic       w_cdb_head;
  logic       w_commit;
  logic       w_redirect;
  logic       w_commit_reg;
  logic       w_commit_store;
  logic       w_issue_ok;

  // Commit decision for the head entry; a CDB write to head defers it a cycle
  always_comb begin
    w_head_op  = r_opcode[r_head];
    w_cdb_head = cdb_sgn && (cdb_name == r_head);
    w_commit   = r_valid[r_head] && r_ready[r_head] && !w_cdb_head &&
                 ((w_head_op != OP_JALR) || r_tgt_rdy[r_head]);
    if (w_commit) begin
      w_redirect = (w_head_op == OP_JALR) ||
                   ((w_head_op == OP_BTYPE) && (r_taken[r_head] != r_jumped[r_head]));
    end else begin
      w_redirect = 1'b0;
    end
    w_commit_reg   = w_commit && f_writes_rd(w_head_op);
    w_commit_store = w_commit && (w_head_op == OP_STYPE);
    w_issue_ok     = issue_sgn && (r_count != C_CAP);
  end

  assign rob_name = r_tail;
  assign rob_full = (r_count >= (C_CAP - C_ONE));

  // Entry storage: CDB capture, store-data snoop, retire and allocate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= '0;
      r_ready   <= '0;
      r_tgt_rdy <= '0;
      r_taken   <= '0;
      r_jumped  <= '0;
    end else if (rdy) begin
      if (w_redirect) begin
        r_valid <= '0;
      end else begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          if (cdb_sgn && r_valid[i] && (cdb_name == ID_W'(i))) begin
            r_ready[i] <= 1'b1;
            case (r_opcode[i])
              OP_BTYPE: r_taken[i] <= cdb_taken;
              OP_JALR: begin
                r_jumpto[i]  <= cdb_target;
                r_tgt_rdy[i] <= 1'b1;
              end
              default:  r_value[i] <= cdb_value;
            endcase
          end else if (cdb_sgn && r_valid[i] && !r_ready[i] && (r_opcode[i] == OP_STYPE) &&
                       (r_value[i][ID_W-1:0] == cdb_name)) begin
            r_ready[i] <= 1'b1;
            r_value[i] <= cdb_value;
          end
        end
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
        end
        // Tail slot is never valid when an issue is accepted, so this cannot collide with the loop above
        if (w_issue_ok) begin
          r_valid[r_tail]   <= 1'b1;
          r_ready[r_tail]   <= issue_ready;
          r_tgt_rdy[r_tail] <= 1'b0;
          r_taken[r_tail]   <= 1'b0;
          r_jumped[r_tail]  <= issue_jumped;
          r_opcode[r_tail]  <= issue_opcode;
          r_value[r_tail]   <= issue_value;
          r_dest[r_tail]    <= issue_dest;
          r_jumpto[r_tail]  <= issue_jumpto;
        end
      end
    end
  end

  // Head/tail pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (w_redirect) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_commit) begin
          r_head <= r_head + C_STEP;
        end
        if (w_issue_ok) begin
          r_tail <= r_tail + C_STEP;
        end
        case ({w_issue_ok, w_commit})
          2'b10:   r_count <= r_count + C_ONE;
          2'b01:   r_count <= r_count - C_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Registered commit/clear outputs; pulses hold while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_reg_sgn   <= 1'b0;
      commit_rd        <= 5'd0;
      commit_value     <= 32'd0;
      commit_name      <= '0;
      commit_store_sgn <= 1'b0;
      commit_lsb_name  <= '0;
      clear_sgn        <= 1'b0;
      clear_pc         <= 32'd0;
    end else if (rdy) begin
      commit_reg_sgn   <= w_commit_reg;
      commit_store_sgn <= w_commit_store;
      clear_sgn        <= w_redirect;
      if (w_commit_reg) begin
        commit_rd    <= r_dest[r_head];
        commit_value <= r_value[r_head];
        commit_name  <= r_head;
      end
      if (w_commit_store) begin
        commit_lsb_name <= r_dest[r_head][ID_W-1:0];
      end
      if (w_redirect) begin
        clear_pc <= r_jumpto[r_head];
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, a full-buffer
// sequence, and randomized traffic against a queue-based reference model.
module tb_reorder_buffer;
  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BTYPE = 6'd5;
  localparam logic [5:0] OP_LTYPE = 6'd6;
  localparam logic [5:0] OP_STYPE = 6'd7;
  localparam logic [5:0] OP_ITYPE = 6'd8;
  localparam logic [5:0] OP_RTYPE = 6'd9;

  logic clk = 1'b0;
  logic rst, rdy, issue_sgn, issue_ready, issue_jumped;
  logic [5:0]  issue_opcode;
  logic [31:0] issue_value, issue_jumpto;
  logic [4:0]  issue_dest;
  logic [3:0]  rob_name;
  logic        rob_full;
  logic        cdb_sgn, cdb_taken;
  logic [3:0]  cdb_name;
  logic [31:0] cdb_value, cdb_target;
  logic        commit_reg_sgn, commit_store_sgn, clear_sgn;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, clear_pc;
  logic [3:0]  commit_name, commit_lsb_name;

  reorder_buffer #(.ROB_SIZE(16), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_sgn(issue_sgn), .issue_opcode(issue_opcode), .issue_ready(issue_ready),
    .issue_value(issue_value), .issue_dest(issue_dest), .issue_jumped(issue_jumped),
    .issue_jumpto(issue_jumpto), .rob_name(rob_name), .rob_full(rob_full),
    .cdb_sgn(cdb_sgn), .cdb_name(cdb_name), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .commit_reg_sgn(commit_reg_sgn), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_name(commit_name), .commit_store_sgn(commit_store_sgn),
    .commit_lsb_name(commit_lsb_name), .clear_sgn(clear_sgn), .clear_pc(clear_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rdy, iss;
    logic [5:0] op;
    logic ir;
    logic [31:0] iv;
    logic [4:0] id;
    logic ij;
    logic [31:0] ijt;
    logic cs;
    logic [3:0] cn;
    logic [31:0] cv;
    logic ct;
    logic [31:0] ctg;
    logic [3:0] e_name;
    logic e_reg;
    logic [4:0] e_rd;
    logic [31:0] e_val;
    logic [3:0] e_cname;
    logic e_st;
    logic [3:0] e_lsb;
    logic e_clr;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [3:0] tag;
    logic [5:0] op;
    logic rd_;
    logic [31:0] val;
    logic [4:0] dest;
    logic jmp;
    logic [31:0] jto;
    logic tk;
    logic trdy;
  } ent_t;

  int vecs = 0;
  int errs = 0;
  vec_t tbl[$];
  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t Z();
    vec_t v;
    v = '{default: '0};
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t R();
    vec_t v;
    v = Z();
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t F();
    vec_t v;
    v = Z();
    v.rdy = 1'b0;
    return v;
  endfunction

  function automatic vec_t I(logic [5:0] op, logic ir, logic [31:0] iv, int id, logic ij, logic [31:0] ijt);
    vec_t v;
    v = Z();
    v.iss = 1'b1; v.op = op; v.ir = ir; v.iv = iv; v.id = 5'(id); v.ij = ij; v.ijt = ijt;
    return v;
  endfunction

  function automatic vec_t C(int cn, logic [31:0] cv, logic ct, logic [31:0] ctg);
    vec_t v;
    v = Z();
    v.cs = 1'b1; v.cn = 4'(cn); v.cv = cv; v.ct = ct; v.ctg = ctg;
    return v;
  endfunction

  function automatic vec_t E(vec_t vi, int nm, logic rg, int rd, logic [31:0] val, int cn,
                             logic st, int lsb, logic clr, logic [31:0] pc);
    vec_t v;
    v = vi;
    v.e_name = 4'(nm); v.e_reg = rg; v.e_rd = 5'(rd); v.e_val = val; v.e_cname = 4'(cn);
    v.e_st = st; v.e_lsb = 4'(lsb); v.e_clr = clr; v.e_pc = pc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; rdy = v.rdy;
    issue_sgn = v.iss; issue_opcode = v.op; issue_ready = v.ir; issue_value = v.iv;
    issue_dest = v.id; issue_jumped = v.ij; issue_jumpto = v.ijt;
    cdb_sgn = v.cs; cdb_name = v.cn; cdb_value = v.cv; cdb_taken = v.ct; cdb_target = v.ctg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic writes_rd(logic [5:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LTYPE, OP_ITYPE, OP_RTYPE};
  endfunction

  logic [5:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BTYPE,
                          OP_LTYPE, OP_STYPE, OP_ITYPE, OP_RTYPE};

  initial begin
    int ncom;
    int m_tail;
    logic m_reg, m_st, m_clr;
    logic [4:0]  m_rd;
    logic [31:0] m_val, m_pc;
    logic [3:0]  m_cname, m_lsb;

    apply(R());
    step(); step();
    chk("reset_name", 32'(rob_name), 32'd0);
    chk("reset_full", 32'(rob_full), 32'd0);
    chk("reset_reg", 32'(commit_reg_sgn), 32'd0);
    chk("reset_store", 32'(commit_store_sgn), 32'd0);
    chk("reset_clear", 32'(clear_sgn), 32'd0);
    chk("reset_value", commit_value, 32'd0);
    chk("reset_pc", clear_pc, 32'd0);

    // LUI commit two edges after issue
    tbl.push_back(E(I(OP_LUI, 1'b1, 32'h12345000, 5, 1'b0, 32'd0), 1, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 1, 1'b1, 5, 32'h12345000, 0, 1'b0, 0, 1'b0, 32'd0));
    // In-order commit of a CDB-resolved RTYPE ahead of a ready ITYPE
    tbl.push_back(E(R(), 0, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(I(OP_RTYPE, 1'b0, 32'd0, 3, 1'b0, 32'd0), 1, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(I(OP_ITYPE, 1'b1, 32'h55, 4, 1'b0, 32'd0), 2, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 2, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(C(0, 32'd7, 1'b0, 32'd0), 2, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 2, 1'b1, 3, 32'd7, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 2, 1'b1, 4, 32'h55, 1, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 2, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    // Mispredicted branch redirects and empties the buffer
    tbl.push_back(E(I(OP_BTYPE, 1'b0, 32'd0, 0, 1'b0, 32'h100), 3, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(C(2, 32'd0, 1'b1, 32'd0), 3, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 0, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b1, 32'h100));
    tbl.push_back(E(Z(), 0, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    // Correctly predicted branch retires silently
    tbl.push_back(E(I(OP_BTYPE, 1'b0, 32'd0, 0, 1'b0, 32'h200), 1, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(C(0, 32'd0, 1'b0, 32'd0), 1, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 1, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    // JALR waits for its target, writes the link value and redirects
    tbl.push_back(E(I(OP_JALR, 1'b1, 32'h24, 1, 1'b0, 32'd0), 2, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 2, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(C(1, 32'h999, 1'b0, 32'h80), 2, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 0, 1'b1, 1, 32'h24, 1, 1'b0, 0, 1'b1, 32'h80));
    tbl.push_back(E(Z(), 0, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    // Store data snooped from the CDB, retired after older entries; rdy=0 holds a pulse
    tbl.push_back(E(I(OP_ITYPE, 1'b1, 32'hA, 6, 1'b0, 32'd0), 1, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(I(OP_ITYPE, 1'b0, 32'd0, 7, 1'b0, 32'd0), 2, 1'b1, 6, 32'hA, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(I(OP_RTYPE, 1'b0, 32'd0, 8, 1'b0, 32'd0), 3, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(I(OP_STYPE, 1'b0, 32'd2, 4, 1'b0, 32'd0), 4, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(C(2, 32'd9, 1'b0, 32'd0), 4, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(C(1, 32'd5, 1'b0, 32'd0), 4, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 4, 1'b1, 7, 32'd5, 1, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(F(), 4, 1'b1, 7, 32'd5, 1, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 4, 1'b1, 8, 32'd9, 2, 1'b0, 0, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 4, 1'b0, 0, 32'd0, 0, 1'b1, 4, 1'b0, 32'd0));
    tbl.push_back(E(Z(), 4, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 32'd0));

    foreach (tbl[k]) begin
      apply(tbl[k]);
      step();
      chk($sformatf("v%0d_name", k), 32'(rob_name), 32'(tbl[k].e_name));
      chk($sformatf("v%0d_full", k), 32'(rob_full), 32'd0);
      chk($sformatf("v%0d_reg", k), 32'(commit_reg_sgn), 32'(tbl[k].e_reg));
      if (tbl[k].e_reg) begin
        chk($sformatf("v%0d_rd", k), 32'(commit_rd), 32'(tbl[k].e_rd));
        chk($sformatf("v%0d_value", k), commit_value, tbl[k].e_val);
        chk($sformatf("v%0d_cname", k), 32'(commit_name), 32'(tbl[k].e_cname));
      end
      chk($sformatf("v%0d_store", k), 32'(commit_store_sgn), 32'(tbl[k].e_st));
      if (tbl[k].e_st) chk($sformatf("v%0d_lsb", k), 32'(commit_lsb_name), 32'(tbl[k].e_lsb));
      chk($sformatf("v%0d_clear", k), 32'(clear_sgn), 32'(tbl[k].e_clr));
      if (tbl[k].e_clr) chk($sformatf("v%0d_pc", k), clear_pc, tbl[k].e_pc);
    end

    // Fill: full flag from count 15, 16th issue fills, 17th is ignored
    apply(R());
    step();
    for (int k = 0; k < 17; k++) begin
      int cnt;
      apply(I(OP_ITYPE, 1'b0, 32'd0, k, 1'b0, 32'd0));
      step();
      cnt = (k + 1 > 16) ? 16 : k + 1;
      chk($sformatf("fill%0d_name", k), 32'(rob_name), 32'(cnt % 16));
      chk($sformatf("fill%0d_full", k), 32'(rob_full), 32'(cnt >= 15));
    end
    ncom = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 16) apply(C(cyc, 32'(cyc * 3 + 1), 1'b0, 32'd0));
      else apply(Z());
      step();
      if (commit_reg_sgn) begin
        chk("drain_cname", 32'(commit_name), 32'(ncom));
        chk("drain_rd", 32'(commit_rd), 32'(ncom));
        chk("drain_value", commit_value, 32'(ncom * 3 + 1));
        ncom++;
      end
    end
    chk("drain_count", 32'(ncom), 32'd16);
    chk("drain_name", 32'(rob_name), 32'd0);
    chk("drain_full", 32'(rob_full), 32'd0);

    // Randomized traffic against a queue model
    apply(R());
    step();
    q.delete();
    m_tail = 0;
    m_reg = 1'b0; m_st = 1'b0; m_clr = 1'b0;
    m_rd = '0; m_val = '0; m_pc = '0; m_cname = '0; m_lsb = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vec_t v;
      v = Z();
      v.rst = ($urandom_range(0, 199) == 0);
      v.rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 6) begin
        v.iss = 1'b1;
        v.op  = ops[$urandom_range(0, 8)];
        v.ir  = 1'($urandom);
        v.iv  = $urandom;
        v.id  = 5'($urandom);
        v.ij  = 1'($urandom);
        v.ijt = $urandom;
        if (v.op == OP_JALR) v.ir = 1'b1;
        if (v.op == OP_BTYPE) v.ir = 1'b0;
        if (v.op == OP_STYPE && !v.ir && q.size() > 0)
          v.iv = 32'(q[$urandom_range(0, q.size() - 1)].tag);
      end
      if ($urandom_range(0, 1) == 1) begin
        int cand[$];
        foreach (q[j]) if (!q[j].rd_ || (q[j].op == OP_JALR && !q[j].trdy)) cand.push_back(j);
        v.cs  = 1'b1;
        v.cn  = (cand.size() > 0) ? q[cand[$urandom_range(0, cand.size() - 1)]].tag : 4'($urandom);
        v.cv  = $urandom;
        v.ct  = 1'($urandom);
        v.ctg = $urandom;
      end
      apply(v);

      if (v.rst) begin
        q.delete();
        m_tail = 0;
        m_reg = 1'b0; m_st = 1'b0; m_clr = 1'b0;
        m_rd = '0; m_val = '0; m_pc = '0; m_cname = '0; m_lsb = '0;
      end else if (v.rdy) begin
        logic commit, was_full;
        ent_t h;
        commit = 1'b0;
        if (q.size() > 0) begin
          h = q[0];
          commit = h.rd_ && (h.op != OP_JALR || h.trdy) && !(v.cs && v.cn == h.tag);
        end
        m_reg = commit && writes_rd(h.op);
        m_st  = commit && (h.op == OP_STYPE);
        m_clr = commit && (h.op == OP_JALR || (h.op == OP_BTYPE && h.tk != h.jmp));
        if (m_reg) begin m_rd = h.dest; m_val = h.val; m_cname = h.tag; end
        if (m_st) m_lsb = h.dest[3:0];
        if (m_clr) m_pc = h.jto;
        was_full = (q.size() == 16);
        if (v.cs) begin
          foreach (q[j]) begin
            if (q[j].tag == v.cn) begin
              q[j].rd_ = 1'b1;
              if (q[j].op == OP_BTYPE) q[j].tk = v.ct;
              else if (q[j].op == OP_JALR) begin q[j].jto = v.ctg; q[j].trdy = 1'b1; end
              else q[j].val = v.cv;
            end else if (q[j].op == OP_STYPE && !q[j].rd_ && q[j].val[3:0] == v.cn) begin
              q[j].rd_ = 1'b1;
              q[j].val = v.cv;
            end
          end
        end
        if (m_clr) begin
          q.delete();
          m_tail = 0;
        end else begin
          if (commit) void'(q.pop_front());
          if (v.iss && !was_full) begin
            ent_t n;
            n.tag = 4'(m_tail); n.op = v.op; n.rd_ = v.ir; n.val = v.iv; n.dest = v.id;
            n.jmp = v.ij; n.jto = v.ijt; n.tk = 1'b0; n.trdy = 1'b0;
            q.push_back(n);
            m_tail = (m_tail + 1) % 16;
          end
        end
      end

      step();
      chk("rnd_name", 32'(rob_name), 32'(m_tail));
      chk("rnd_full", 32'(rob_full), 32'(q.size() >= 15));
      chk("rnd_reg", 32'(commit_reg_sgn), 32'(m_reg));
      chk("rnd_store", 32'(commit_store_sgn), 32'(m_st));
      chk("rnd_clear", 32'(clear_sgn), 32'(m_clr));
      if (m_reg) begin
        chk("rnd_rd", 32'(commit_rd), 32'(m_rd));
        chk("rnd_value", commit_value, m_val);
        chk("rnd_cname", 32'(commit_name), 32'(m_cname));
      end
      if (m_st) chk("rnd_lsb", 32'(commit_lsb_name), 32'(m_lsb));
      if (m_clr) chk("rnd_pc", clear_pc, m_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
